// File: rtl/ram_pkg.sv
// Shared types, read-under-write selectors and the lane merge used by
// both the write path and the read-port forwarding logic.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } ram_state_t;

    localparam int RUW_W     = 80;
    localparam int MAX_W     = 256;
    localparam int MAX_LANES = 32;

    localparam logic [RUW_W-1:0] RUW_WRITE_FIRST = "writeFirst";
    localparam logic [RUW_W-1:0] RUW_READ_FIRST  = {8'h00, "readFirst"};

    // Lanes whose mask bit is set take new_w, all others keep old_w.
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0]     old_w,
        input logic [MAX_W-1:0]     new_w,
        input logic [MAX_LANES-1:0] mask,
        input int                   mask_w,
        input int                   lane_w
    );
        logic [MAX_W-1:0] res;
        int               lane;
        int               pos;
        res  = old_w;
        lane = 0;
        pos  = 0;
        for (int b = 0; b < MAX_W; b++) begin
            if (lane < mask_w && mask[lane]) begin
                res[b] = new_w[b];
            end
            pos++;
            if (pos == lane_w) begin
                pos = 0;
                lane++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_read_port.sv
// One synchronous read port: range check, same-cycle write forwarding and
// output/valid registers. RAM_1W_NRS_OUTREG_EN adds a second output stage.
module ram_read_port
    import ram_pkg::*;
#(
    parameter int               wordCount      = 64,
    parameter int               wordWidth      = 32,
    parameter int               maskWidth      = 4,
    parameter int               addressWidth   = 6,
    parameter logic [RUW_W-1:0] readUnderWrite = RUW_WRITE_FIRST
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rd_en_i,
    input  logic [addressWidth-1:0] rd_addr_i,
    input  logic [wordWidth-1:0]    mem_rdata_i,
    input  logic                    wr_en_i,
    input  logic [addressWidth-1:0] wr_addr_i,
    input  logic [wordWidth-1:0]    wr_data_i,
    input  logic [maskWidth-1:0]    wr_mask_i,
    output logic [wordWidth-1:0]    rd_data_o,
    output logic                    rd_valid_o
);

    localparam int                  LANE_W = wordWidth / maskWidth;
    localparam logic [addressWidth:0] WORDS = (addressWidth+1)'(wordCount);

    logic                 in_range;
    logic                 hit;
    logic [MAX_W-1:0]     merged;
    logic [wordWidth-1:0] word_p0_d;
    logic [wordWidth-1:0] data_p1_q;
    logic                 vld_p1_q;

    assign in_range = ({1'b0, rd_addr_i} < WORDS);
    assign hit      = wr_en_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        merged    = lane_merge(MAX_W'(mem_rdata_i), MAX_W'(wr_data_i),
                               MAX_LANES'(wr_mask_i), maskWidth, LANE_W);
        word_p0_d = mem_rdata_i;
        if (!in_range) begin
            word_p0_d = '0;
        end else if (hit && readUnderWrite == RUW_WRITE_FIRST) begin
            word_p0_d = merged[wordWidth-1:0];
        end
    end

    // stage p1: capture (forwarding already resolved)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else begin
            vld_p1_q <= rd_en_i;
            if (rd_en_i) begin
                data_p1_q <= word_p0_d;
            end
        end
    end

`ifdef RAM_1W_NRS_OUTREG_EN
    logic [wordWidth-1:0] data_p2_q;
    logic                 vld_p2_q;

    // stage p2: optional output register, loads only behind a valid p1
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_p2_q <= '0;
            vld_p2_q  <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                data_p2_q <= data_p1_q;
            end
        end
    end

    assign rd_data_o  = data_p2_q;
    assign rd_valid_o = vld_p2_q;
`else
    assign rd_data_o  = data_p1_q;
    assign rd_valid_o = vld_p1_q;
`endif

endmodule

// File: rtl/ram_1w_nrs_bypass.sv
// Byte-masked 1W/NR block RAM with post-reset zero sweep and per-port forwarding.
// Define RAM_1W_NRS_OUTREG_EN for a second output register (read latency 2).
module ram_1w_nrs_bypass
    import ram_pkg::*;
#(
    parameter int               wordCount      = 64,
    parameter int               wordWidth      = 32,
    parameter int               maskWidth      = 4,
    parameter int               addressWidth   = 6,
    parameter int               readPorts      = 2,
    parameter logic [RUW_W-1:0] readUnderWrite = RUW_WRITE_FIRST
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              wr_en,
    input  logic [maskWidth-1:0]              wr_mask,
    input  logic [addressWidth-1:0]           wr_addr,
    input  logic [wordWidth-1:0]              wr_data,
    input  logic [readPorts-1:0]              rd_en,
    input  logic [readPorts*addressWidth-1:0] rd_addr,
    output logic [readPorts*wordWidth-1:0]    rd_data,
    output logic [readPorts-1:0]              rd_valid,
    output logic                              init_busy
);

    localparam int                      LANE_W = wordWidth / maskWidth;
    localparam logic [addressWidth:0]   WORDS  = (addressWidth+1)'(wordCount);
    localparam logic [addressWidth-1:0] LAST   = addressWidth'(wordCount - 1);

    ram_state_t              state_q, state_d;
    logic [addressWidth-1:0] clear_ptr_q, clear_ptr_d;
    logic                    run;

    logic [wordWidth-1:0]    mem [wordCount];
    logic                    mem_we;
    logic [addressWidth-1:0] mem_waddr;
    logic [wordWidth-1:0]    mem_wdata;
    logic [maskWidth-1:0]    mem_wmask;
    logic [MAX_W-1:0]        wr_merged;
    logic                    wr_fwd;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        init_busy   = 1'b0;
        run         = 1'b0;
        case (state_q)
            CLEAR: begin
                init_busy   = 1'b1;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == LAST) begin
                    state_d     = RUN;
                    clear_ptr_d = '0;
                end
            end
            default: run = 1'b1;
        endcase
    end

    // The sweep owns the write port while clearing; external writes are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        mem_wmask = wr_mask;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = clear_ptr_q;
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (wr_en && ({1'b0, wr_addr} < WORDS)) begin
            mem_we = 1'b1;
        end
    end

    assign wr_fwd = mem_we & run;

    always_comb begin
        wr_merged = lane_merge(MAX_W'(mem[mem_we ? mem_waddr : '0]), MAX_W'(mem_wdata),
                               MAX_LANES'(mem_wmask), maskWidth, LANE_W);
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wr_merged[wordWidth-1:0];
        end
    end

    for (genvar p = 0; p < readPorts; p++) begin : g_port
        logic [addressWidth-1:0] ra;
        logic [addressWidth-1:0] ra_safe;

        assign ra      = rd_addr[p*addressWidth +: addressWidth];
        assign ra_safe = ({1'b0, ra} < WORDS) ? ra : '0;

        ram_read_port #(
            .wordCount      (wordCount),
            .wordWidth      (wordWidth),
            .maskWidth      (maskWidth),
            .addressWidth   (addressWidth),
            .readUnderWrite (readUnderWrite)
        ) u_port (
            .clk         (clk),
            .resetn      (resetn),
            .rd_en_i     (rd_en[p] & run),
            .rd_addr_i   (ra),
            .mem_rdata_i (mem[ra_safe]),
            .wr_en_i     (wr_fwd),
            .wr_addr_i   (wr_addr),
            .wr_data_i   (wr_data),
            .wr_mask_i   (wr_mask),
            .rd_data_o   (rd_data[p*wordWidth +: wordWidth]),
            .rd_valid_o  (rd_valid[p])
        );
    end

endmodule

// File: doc/ram_1w_nrs_bypass.md
# ram_1w_nrs_bypass

Single-clock block RAM with one byte-masked write port and `readPorts` independent synchronous read ports. It adds a hardware zero-initialisation sweep after reset, per-port read-during-write forwarding and per-port read-valid tracking. It serves register files, branch-predictor tables and cache tag/data arrays, which need deterministic contents after reset and more than one read per cycle.

## Interface
- `wordCount`, 64: number of words; need not be a power of two.
- `wordWidth`, 32: bits per word.
- `maskWidth`, 4: write-mask lanes; `wordWidth % maskWidth == 0`; lane width `LW = wordWidth/maskWidth`.
- `addressWidth`, 6: address bits; `2**addressWidth >= wordCount`.
- `readPorts`, 2: number of read ports, 1..4.
- `readUnderWrite`, "writeFirst": same-cycle same-address behaviour, "writeFirst" or "readFirst".
- `clk` input 1: single clock for all ports.
- `resetn` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write request.
- `wr_mask` input maskWidth: lane enables.
- `wr_addr` input addressWidth: write address.
- `wr_data` input wordWidth: write data.
- `rd_en` input readPorts: per-port read request.
- `rd_addr` input readPorts*addressWidth: port p at `[p*addressWidth +: addressWidth]`.
- `rd_data` output readPorts*wordWidth: port p at `[p*wordWidth +: wordWidth]`.
- `rd_valid` output readPorts: `rd_data` slice of port p holds the result of an accepted read.
- `init_busy` output 1: zero-initialisation sweep in progress.

## Operation
- **State machine**, two states: CLEAR and RUN.
  - Reset enters CLEAR with `clear_ptr = 0`.
  - CLEAR: each cycle writes all-zero, full mask, at `clear_ptr`, then increments it. The cycle that writes `wordCount-1` moves the FSM to RUN.
- **During CLEAR**: `wr_en` and `rd_en` are ignored. External writes are dropped, not queued. `rd_valid` stays 0. `init_busy = 1`.
- **RUN writes**: `wr_en=1` updates lane i of `mem[wr_addr]` only where `wr_mask[i]=1`. `wr_addr >= wordCount` drops the write.
- **RUN reads, per port p**: `rd_en[p]=1` captures `mem[rd_addr_p]` into the output register. `rd_addr_p >= wordCount` returns all-zero.
- **Read disabled**: `rd_en[p]=0` holds that port's `rd_data` slice and clears `rd_valid[p]` on the next edge.
- **Collision** (same cycle, same address, `wr_en` and `rd_en[p]` both 1):
  - "writeFirst": lanes with `wr_mask` set return `wr_data`; other lanes return the old memory value.
  - "readFirst": the whole word returns the old value.
- Ports are fully independent. Any number of ports may read the same address in the same cycle.
- **Reset mid-operation**, including mid-CLEAR: all outputs go to their reset values immediately. The sweep restarts from address 0 and memory is re-zeroed.

## Timing
- Reset values: `rd_data = 0`, `rd_valid = 0`, `init_busy = 1`.
- `init_busy` falls exactly `wordCount` rising edges after `resetn` deasserts.
- The first RUN cycle accepts reads and writes.
- Read latency is 1 cycle: `rd_en` at edge N gives `rd_data` and `rd_valid` after edge N+1. With `RAM_1W_NRS_OUTREG_EN` it is 2 cycles.
- A write at edge N is visible to a non-colliding read issued at edge N+1.
- Throughput: one write plus `readPorts` reads every cycle, with no stalls in RUN.

## Configuration
- `RAM_1W_NRS_OUTREG_EN` defined:
  - Adds a second output register per port, so read latency is 2 and `rd_valid` is delayed to match.
  - Forwarding is still resolved in the first stage.
  - `rd_en=0` holds both stages and clears the valid bit of the stage being loaded.
  - Reset clears both stages.
- Macro undefined: single output register, read latency 1.

## Structure
- Package `ram_pkg`:
  - State enum `ram_state_t` {CLEAR, RUN}.
  - Read-under-write constants `RUW_WRITE_FIRST` and `RUW_READ_FIRST`.
  - Function `lane_merge(old, new, mask, maskWidth)` for the forwarding merge.
- Sub-module `ram_read_port`, instantiated `readPorts` times via generate. Each instance holds:
  - the address-range check;
  - the collision compare and merge;
  - the output and valid registers;
  - the optional second stage.
- The top level owns the memory array, the write path and the CLEAR FSM/counter.

## Test plan
- Reset release, `wordCount=64` → `init_busy` high for 64 cycles. `rd_en` during the sweep gives `rd_valid=0`. Every address then reads `0x00000000`.
- Write `0xDEADBEEF` to addr 5 with mask `4'b0101`, then read addr 5 on port 1 → `0x00AD00EF` with `rd_valid[1]=1`, exactly 1 cycle later (2 with macro).
- Addr 7 holds `0x11223344`. Same-cycle write `0xAABBCCDD`, mask `4'b1100`, plus port 0 read of addr 7 → writeFirst gives `0xAABB3344`; readFirst gives `0x11223344`.
- Both ports read addr 3 (`0xCAFEF00D`) and addr 9 (`0x0BADBEEF`) in the same cycle → each port returns its own word. Dropping `rd_en` holds the data with `rd_valid=0`.
- Assert `resetn` low at sweep address 30 after addr 2 was written before reset → the sweep restarts at 0, `init_busy` lasts 64 more cycles, and addr 2 reads 0.
- `wordCount=48`: write addr 50 and read addr 50 → the write is dropped, the read returns 0, and the contents of addr 50 mod 48 are unchanged.
